hss_envelope_decimator: RTL and testbench

Downstream stage of the Butterworth low-pass filter in the HSS front end. It rectifies the filtered signed sample stream, averages the magnitude over fixed windows of DECIM valid samples, and queues the decimated envelope values in a small FIFO. The AIRISC peripheral side drains the FIFO through a valid/ready handshake. Overflow is reported through a sticky flag, so software can tell when envelope samples were lost.

---
 rtl/hss_envelope_decimator_pkg.sv | 24 ++
 rtl/hss_envelope_decimator_sync_fifo.sv | 75 +++++++
 rtl/hss_envelope_decimator.sv | 101 ++++++++++
 tb/tb_hss_envelope_decimator.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hss_envelope_decimator_pkg.sv
// Shared defaults and helpers for the HSS envelope path.
// Holds the default window/queue sizing and the rectifier saturation constant.
// Ports: none (package).
package hss_envelope_decimator_pkg;

    localparam int unsigned DECIM_DEF      = 16;
    localparam int unsigned LOG2_DECIM_DEF = 4;
    localparam int unsigned FIFO_DEPTH_DEF = 4;

    // |-2^31| does not fit in 31 magnitude bits, so it is clamped here.
    localparam logic [31:0] SAT_MAG = 32'h7FFF_FFFF;

    // Magnitude of a two's-complement sample, saturating the most negative value.
    function automatic logic [31:0] rectify(input logic [31:0] s);
        if (s == 32'h8000_0000) begin
            return SAT_MAG;
        end else if (s[31]) begin
            return ~s + 32'd1;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/hss_envelope_decimator_sync_fifo.sv
// hss_sync_fifo: single-clock FIFO with a registered head output.
// Latency: a push into an empty FIFO is visible on head one edge later.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
// Ports: CLK/RST, push/push_dat, pop, head, full, empty.
module hss_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = head_q;

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_dat;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        // Preload the head register with whatever entry will be oldest after
        // this edge; if that entry is the one being written now, bypass it.
        if (rd_ptr_d != wr_ptr_d) begin
            if (rd_ptr_d == wr_ptr_q) begin
                head_d = push_dat;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/hss_envelope_decimator.sv
// Rectify the filtered sample stream, average |data| over DECIM valid samples, queue results.
// Latency: the result of a window is on out_data one edge after its last sample (empty queue).
// Backpressure: out_valid/out_ready drain; a result arriving at a full, non-popping queue is dropped and sets sticky overflow.
// Ports: CLK/RST, data/data_valid in, out_data/out_valid/out_ready out, overflow/clear status.
module hss_envelope_decimator
    import hss_envelope_decimator_pkg::*;
#(
    parameter int unsigned DECIM      = DECIM_DEF,
    parameter int unsigned LOG2_DECIM = LOG2_DECIM_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] data,
    input  logic        data_valid,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        clear
);

    // DECIM magnitudes of at most 2^31-1 fit in 32+LOG2_DECIM bits, so no wrap.
    localparam int unsigned ACC_W = 32 + LOG2_DECIM;

    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
    logic                  overflow_q, overflow_d;

    logic [31:0]      mag;
    logic [ACC_W-1:0] sum;
    logic             win_done;
    logic [31:0]      result;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             ovf_evt;

    assign mag      = rectify(data);
    assign sum      = acc_q + {{LOG2_DECIM{1'b0}}, mag};
    assign win_done = data_valid && (cnt_q == LOG2_DECIM'(DECIM - 1));
    // Dividing by a power of two: drop the low bits, keeping a 32-bit mean.
    assign result   = sum[ACC_W-1:LOG2_DECIM];

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign ovf_evt   = win_done && fifo_full && !pop;

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (data_valid) begin
            if (win_done) begin
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A drop in the same cycle as clear must remain visible to software.
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_evt) begin
            overflow_d = 1'b1;
        end else if (clear) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;

    hss_sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST      (RST),
        .push     (win_done),
        .push_dat (result),
        .pop      (pop),
        .head     (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_hss_envelope_decimator.sv
module tb_hss_envelope_decimator;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] data = '0;
    logic        data_valid = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        clear = 1'b0;

    int total = 0;
    int bad   = 0;

    // Reference model: samples of the current window, queued results, sticky flag.
    longint      win_s[$];
    logic [31:0] mq[$];
    logic        m_ovf = 1'b0;

    always #5 CLK = ~CLK;

    hss_envelope_decimator #(
        .DECIM      (4),
        .LOG2_DECIM (2),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .data       (data),
        .data_valid (data_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overflow   (overflow),
        .clear      (clear)
    );

    function automatic longint abs_sat(input logic [31:0] d);
        longint v;
        v = longint'($signed(d));
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    task automatic check_outputs(input string tag);
        logic exp_vld;
        exp_vld = (mq.size() > 0);
        total++;
        assert (out_valid === exp_vld) else begin
            bad++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, out_valid, exp_vld);
        end
        total++;
        assert (overflow === m_ovf) else begin
            bad++;
            $error("FAIL %s overflow observed=%b expected=%b", tag, overflow, m_ovf);
        end
        if (exp_vld) begin
            total++;
            assert (out_data === mq[0]) else begin
                bad++;
                $error("FAIL %s out_data observed=%h expected=%h", tag, out_data, mq[0]);
            end
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, then check.
    task automatic step(input logic [31:0] d, input bit v, input bit rdy, input bit clr,
                        input string tag);
        bit     do_pop;
        bit     have;
        bit     evt;
        longint s;
        logic [31:0] r;
        data       = d;
        data_valid = v;
        out_ready  = rdy;
        clear      = clr;
        @(posedge CLK);
        do_pop = rdy && (mq.size() > 0);
        have   = 0;
        evt    = 0;
        r      = '0;
        if (v) begin
            win_s.push_back(abs_sat(d));
            if (win_s.size() == 4) begin
                s = 0;
                foreach (win_s[i]) s += win_s[i];
                r = 32'(s / 4);
                have = 1;
                win_s.delete();
            end
        end
        if (have && mq.size() >= 4 && !do_pop) evt = 1;
        if (do_pop) void'(mq.pop_front());
        if (have && !evt) mq.push_back(r);
        if (evt) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        #1;
        check_outputs(tag);
    endtask

    task automatic window(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [31:0] d, input bit rdy_last, input bit clr_last,
                          input string tag);
        step(a, 1, 0, 0, tag);
        step(b, 1, 0, 0, tag);
        step(c, 1, 0, 0, tag);
        step(d, 1, rdy_last, clr_last, tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 6; i++) step(32'd0, 0, 1, 0, tag);
    endtask

    task automatic do_reset(input string tag);
        RST        = 1'b1;
        data_valid = 1'b0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        win_s.delete();
        mq.delete();
        m_ovf = 1'b0;
        RST   = 1'b0;
        check_outputs(tag);
        total++;
        assert (out_data === 32'd0) else begin
            bad++;
            $error("FAIL %s out_data observed=%h expected=%h", tag, out_data, 32'd0);
        end
    endtask

    initial begin
        do_reset("reset");

        // Constant window and latency: valid appears right after the 4th sample.
        window(32'd1000, 32'd1000, 32'd1000, 32'd1000, 0, 0, "const1000");
        drain("const1000_drain");

        window(-32'sd8, 32'd8, -32'sd8, 32'd8, 0, 0, "alt8");
        drain("alt8_drain");

        window(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0, 0, "saturate");
        drain("saturate_drain");

        window(32'd1, 32'd1, 32'd1, 32'd2, 0, 0, "truncate");
        drain("truncate_drain");

        // Gaps between valid samples leave the window state untouched.
        step(32'd4, 1, 0, 0, "gaps");
        for (int i = 0; i < 3; i++) step(32'($urandom), 0, 0, 0, "gaps");
        step(32'd0, 1, 0, 0, "gaps");
        for (int i = 0; i < 3; i++) step(32'($urandom), 0, 0, 0, "gaps");
        step(32'd0, 1, 0, 0, "gaps");
        for (int i = 0; i < 3; i++) step(32'($urandom), 0, 0, 0, "gaps");
        step(32'd4, 1, 0, 0, "gaps");
        drain("gaps_drain");

        // Five windows into a four-entry queue with no consumer.
        window(32'd10, 32'd10, 32'd10, 32'd10, 0, 0, "ovf_fill");
        window(32'd20, 32'd20, 32'd20, 32'd20, 0, 0, "ovf_fill");
        window(32'd30, 32'd30, 32'd30, 32'd30, 0, 0, "ovf_fill");
        window(32'd40, 32'd40, 32'd40, 32'd40, 0, 0, "ovf_fill");
        window(32'd50, 32'd50, 32'd50, 32'd50, 0, 0, "ovf_drop");
        drain("ovf_drain");
        step(32'd0, 0, 0, 1, "ovf_clear");

        // Push into a full queue while it is being popped.
        window(32'd1, 32'd1, 32'd1, 32'd1, 0, 0, "fullpop_fill");
        window(32'd2, 32'd2, 32'd2, 32'd2, 0, 0, "fullpop_fill");
        window(32'd3, 32'd3, 32'd3, 32'd3, 0, 0, "fullpop_fill");
        window(32'd4, 32'd4, 32'd4, 32'd4, 0, 0, "fullpop_fill");
        window(32'd5, 32'd5, 32'd5, 32'd5, 1, 0, "fullpop_push");
        // Drop and clear in the same cycle: the flag must stay set.
        window(32'd6, 32'd6, 32'd6, 32'd6, 0, 1, "set_wins");
        drain("fullpop_drain");
        step(32'd0, 0, 0, 1, "fullpop_clear");

        // Reset in the middle of a window discards the partial sum.
        step(32'd100, 1, 0, 0, "midreset_pre");
        step(32'd100, 1, 0, 0, "midreset_pre");
        do_reset("midreset");
        window(32'd40, 32'd40, 32'd40, 32'd40, 0, 0, "midreset_post");
        drain("midreset_drain");

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 7))
                0:       d = 32'h8000_0000;
                1:       d = 32'($urandom_range(0, 20)) - 32'd10;
                default: d = 32'($urandom);
            endcase
            step(d, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 15) == 0, "random");
        end
        drain("random_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
